// File: rtl/decode_cycle_if.sv
`default_nettype none
// ============================================================================
// Module   : decode_cycle_if
// Purpose  : ID/EX pipeline bundle between the decode stage and execute stage.
//            master = decode stage (drives the registered ID/EX fields),
//            slave  = execute stage (consumes them).
// Signals  : RegWriteE, ALUSrcE, MemWriteE, ResultSrcE[1:0], BranchE, JumpE,
//            ALUControlE[2:0], RD1_E[31:0], RD2_E[31:0], Imm_Ext_E[31:0],
//            RS1_E[4:0], RS2_E[4:0], RD_E[4:0], PCE[31:0], PCPlus4E[31:0]
// Revision : 1.0 - initial release
// ============================================================================
interface decode_cycle_if;
  logic        RegWriteE;
  logic        ALUSrcE;
  logic        MemWriteE;
  logic [1:0]  ResultSrcE;
  logic        BranchE;
  logic        JumpE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1_E;
  logic [31:0] RD2_E;
  logic [31:0] Imm_Ext_E;
  logic [4:0]  RS1_E;
  logic [4:0]  RS2_E;
  logic [4:0]  RD_E;
  logic [31:0] PCE;
  logic [31:0] PCPlus4E;

  modport master (
    output RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, JumpE,
           ALUControlE, RD1_E, RD2_E, Imm_Ext_E, RS1_E, RS2_E, RD_E,
           PCE, PCPlus4E
  );

  modport slave (
    input  RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, JumpE,
           ALUControlE, RD1_E, RD2_E, Imm_Ext_E, RS1_E, RS2_E, RD_E,
           PCE, PCPlus4E
  );
endinterface
`default_nettype wire

// File: rtl/decode_cycle.sv
`default_nettype none
// ============================================================================
// Module   : decode_cycle
// Purpose  : RV32I decode stage. Decodes InstrD into control signals, reads
//            the 32x32 register file, sign-extends the immediate and registers
//            everything into the ID/EX pipeline register. Also hosts the
//            writeback write port of the register file.
// Ports    : clk       - pipeline clock, rising edge
//            rst       - synchronous active-low reset
//            InstrD    - instruction from IF/ID
//            PCD       - PC of InstrD
//            PCPlus4D  - PC+4 of InstrD
//            RegWriteW - writeback register-file write enable
//            RDW       - writeback destination register
//            ResultW   - writeback data
//            FlushE    - insert a bubble into ID/EX
//            ex        - ID/EX bundle (decode_cycle_if.master)
// Params   : RF_INIT_ZERO - 1: x1..x31 clear on reset; 0: contents survive
// Macros   : DECODE_WB_BYPASS_EN - when defined, a same-cycle writeback to a
//            register being read is forwarded to the read port.
// Revision : 1.0 - initial release
// ============================================================================
module decode_cycle #(
  parameter int RF_INIT_ZERO = 1
) (
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic [31:0] InstrD,
  input  wire logic [31:0] PCD,
  input  wire logic [31:0] PCPlus4D,
  input  wire logic        RegWriteW,
  input  wire logic [4:0]  RDW,
  input  wire logic [31:0] ResultW,
  input  wire logic        FlushE,
  decode_cycle_if.master   ex
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_IALU = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  typedef enum logic [1:0] {
    IMM_I = 2'd0,
    IMM_S = 2'd1,
    IMM_B = 2'd2,
    IMM_J = 2'd3
  } imm_sel_t;

  // Instruction fields
  logic [6:0] opcode;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic [4:0] rd;
  logic [2:0] funct3;
  logic       funct7_b5;

  assign opcode    = InstrD[6:0];
  assign rd        = InstrD[11:7];
  assign funct3    = InstrD[14:12];
  assign rs1       = InstrD[19:15];
  assign rs2       = InstrD[24:20];
  assign funct7_b5 = InstrD[30];

  // --------------------------------------------------------------------------
  // Register file
  // --------------------------------------------------------------------------
  // Entry 0 is never written; reads of index 0 are forced to zero instead.
  logic [31:0] regs [32];
  logic        wb_we;

  assign wb_we = RegWriteW && (RDW != 5'd0);

  generate
    if (RF_INIT_ZERO != 0) begin : g_rf_clear
      always_ff @(posedge clk) begin
        if (!rst) begin
          for (int i = 1; i < 32; i++) begin
            regs[i] <= '0;
          end
        end else if (wb_we) begin
          regs[RDW] <= ResultW;
        end
      end
    end else begin : g_rf_keep
      // Contents survive reset, but a write coinciding with reset is dropped.
      always_ff @(posedge clk) begin
        if (rst && wb_we) begin
          regs[RDW] <= ResultW;
        end
      end
    end
  endgenerate

  logic [31:0] rd1;
  logic [31:0] rd2;

`ifdef DECODE_WB_BYPASS_EN
  assign rd1 = (rs1 == 5'd0)               ? 32'd0   :
               (wb_we && (RDW == rs1))     ? ResultW : regs[rs1];
  assign rd2 = (rs2 == 5'd0)               ? 32'd0   :
               (wb_we && (RDW == rs2))     ? ResultW : regs[rs2];
`else
  assign rd1 = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
  assign rd2 = (rs2 == 5'd0) ? 32'd0 : regs[rs2];
`endif

  // --------------------------------------------------------------------------
  // Main control decode
  // --------------------------------------------------------------------------
  logic       reg_write;
  logic       alu_src;
  logic       mem_write;
  logic [1:0] result_src;
  logic       branch;
  logic       jump;
  logic [1:0] alu_op;
  imm_sel_t   imm_sel;

  always_comb begin
    reg_write  = 1'b0;
    alu_src    = 1'b0;
    mem_write  = 1'b0;
    result_src = 2'b00;
    branch     = 1'b0;
    jump       = 1'b0;
    alu_op     = 2'b00;
    imm_sel    = IMM_I;
    case (opcode)
      OP_LW: begin
        reg_write  = 1'b1;
        alu_src    = 1'b1;
        result_src = 2'b01;
      end
      OP_SW: begin
        mem_write = 1'b1;
        alu_src   = 1'b1;
        imm_sel   = IMM_S;
      end
      OP_R: begin
        reg_write = 1'b1;
        alu_op    = 2'b10;
      end
      OP_IALU: begin
        reg_write = 1'b1;
        alu_src   = 1'b1;
        alu_op    = 2'b10;
      end
      OP_BEQ: begin
        branch  = 1'b1;
        alu_op  = 2'b01;
        imm_sel = IMM_B;
      end
      OP_JAL: begin
        reg_write  = 1'b1;
        jump       = 1'b1;
        result_src = 2'b10;
        imm_sel    = IMM_J;
      end
      default: begin
        // Unknown opcodes decode as a NOP.
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // ALU control decode
  // --------------------------------------------------------------------------
  logic [2:0] alu_ctl;

  always_comb begin
    alu_ctl = 3'b000;
    case (alu_op)
      2'b00: alu_ctl = 3'b000;
      2'b01: alu_ctl = 3'b001;
      2'b10: begin
        case (funct3)
          // Only R-type with funct7[5] set is a subtract; addi never is.
          3'b000:  alu_ctl = ({opcode[5], funct7_b5} == 2'b11) ? 3'b001 : 3'b000;
          3'b010:  alu_ctl = 3'b101;
          3'b110:  alu_ctl = 3'b011;
          3'b111:  alu_ctl = 3'b010;
          default: alu_ctl = 3'b000;
        endcase
      end
      default: alu_ctl = 3'b000;
    endcase
  end

  // --------------------------------------------------------------------------
  // Immediate generation
  // --------------------------------------------------------------------------
  logic [31:0] imm_ext;

  always_comb begin
    imm_ext = {{20{InstrD[31]}}, InstrD[31:20]};
    case (imm_sel)
      IMM_I: imm_ext = {{20{InstrD[31]}}, InstrD[31:20]};
      IMM_S: imm_ext = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
      IMM_B: imm_ext = {{20{InstrD[31]}}, InstrD[7], InstrD[30:25],
                        InstrD[11:8], 1'b0};
      IMM_J: imm_ext = {{12{InstrD[31]}}, InstrD[19:12], InstrD[20],
                        InstrD[30:21], 1'b0};
      default: imm_ext = {{20{InstrD[31]}}, InstrD[31:20]};
    endcase
  end

  // --------------------------------------------------------------------------
  // ID/EX pipeline register. Reset and flush both load an all-zero bubble.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst || FlushE) begin
      ex.RegWriteE   <= 1'b0;
      ex.ALUSrcE     <= 1'b0;
      ex.MemWriteE   <= 1'b0;
      ex.ResultSrcE  <= 2'b00;
      ex.BranchE     <= 1'b0;
      ex.JumpE       <= 1'b0;
      ex.ALUControlE <= 3'b000;
      ex.RD1_E       <= '0;
      ex.RD2_E       <= '0;
      ex.Imm_Ext_E   <= '0;
      ex.RS1_E       <= '0;
      ex.RS2_E       <= '0;
      ex.RD_E        <= '0;
      ex.PCE         <= '0;
      ex.PCPlus4E    <= '0;
    end else begin
      ex.RegWriteE   <= reg_write;
      ex.ALUSrcE     <= alu_src;
      ex.MemWriteE   <= mem_write;
      ex.ResultSrcE  <= result_src;
      ex.BranchE     <= branch;
      ex.JumpE       <= jump;
      ex.ALUControlE <= alu_ctl;
      ex.RD1_E       <= rd1;
      ex.RD2_E       <= rd2;
      ex.Imm_Ext_E   <= imm_ext;
      ex.RS1_E       <= rs1;
      ex.RS2_E       <= rs2;
      ex.RD_E        <= rd;
      ex.PCE         <= PCD;
      ex.PCPlus4E    <= PCPlus4D;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_decode_cycle.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_cycle
// Purpose  : Self-checking bench for decode_cycle. A table of per-cycle
//            {inputs, expected ID/EX contents} records drives most checks;
//            short hand-written sequences cover bypass, reset-vs-write and
//            flush-with-write corner cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_decode_cycle;

  logic        clk;
  logic        rst;
  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic [31:0] PCPlus4D;
  logic        RegWriteW;
  logic [4:0]  RDW;
  logic [31:0] ResultW;
  logic        FlushE;

  decode_cycle_if ex_if ();

  decode_cycle #(.RF_INIT_ZERO(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .InstrD    (InstrD),
    .PCD       (PCD),
    .PCPlus4D  (PCPlus4D),
    .RegWriteW (RegWriteW),
    .RDW       (RDW),
    .ResultW   (ResultW),
    .FlushE    (FlushE),
    .ex        (ex_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Control word packing: {RegWrite, ALUSrc, MemWrite, ResultSrc[1:0],
  //                        Branch, Jump, ALUControl[2:0]}
  localparam logic [9:0] C_NONE = 10'b0000000000;
  localparam logic [9:0] C_ADD  = 10'b1000000000;
  localparam logic [9:0] C_SUB  = 10'b1000000001;
  localparam logic [9:0] C_SLT  = 10'b1000000101;
  localparam logic [9:0] C_OR   = 10'b1000000011;
  localparam logic [9:0] C_LW   = 10'b1100100000;
  localparam logic [9:0] C_SW   = 10'b0110000000;
  localparam logic [9:0] C_ADDI = 10'b1100000000;
  localparam logic [9:0] C_ANDI = 10'b1100000010;
  localparam logic [9:0] C_BEQ  = 10'b0000010001;
  localparam logic [9:0] C_JAL  = 10'b1001001000;

  typedef struct {
    logic        rst;
    logic        flush;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        wen;
    logic [4:0]  rdw;
    logic [31:0] resw;
    logic [9:0]  ctl;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic rst_i, input logic flush_i, input logic [31:0] instr_i,
    input logic [31:0] pc_i, input logic wen_i, input logic [4:0] rdw_i,
    input logic [31:0] resw_i, input logic [9:0] ctl_i,
    input logic [31:0] rd1_i, input logic [31:0] rd2_i,
    input logic [31:0] imm_i, input logic [4:0] rs1_i,
    input logic [4:0] rs2_i, input logic [4:0] rd_i);
    vec_t v;
    v.rst = rst_i;  v.flush = flush_i; v.instr = instr_i; v.pc = pc_i;
    v.wen = wen_i;  v.rdw = rdw_i;     v.resw = resw_i;   v.ctl = ctl_i;
    v.rd1 = rd1_i;  v.rd2 = rd2_i;     v.imm = imm_i;
    v.rs1 = rs1_i;  v.rs2 = rs2_i;     v.rd = rd_i;
    return v;
  endfunction

  function automatic logic [9:0] act_ctl();
    return {ex_if.RegWriteE, ex_if.ALUSrcE, ex_if.MemWriteE, ex_if.ResultSrcE,
            ex_if.BranchE, ex_if.JumpE, ex_if.ALUControlE};
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, clock it, and sample 1 ns after the edge.
  task automatic step(input logic rst_i, input logic flush_i,
                      input logic [31:0] instr_i, input logic [31:0] pc_i,
                      input logic wen_i, input logic [4:0] rdw_i,
                      input logic [31:0] resw_i);
    rst       = rst_i;
    FlushE    = flush_i;
    InstrD    = instr_i;
    PCD       = pc_i;
    PCPlus4D  = pc_i + 32'd4;
    RegWriteW = wen_i;
    RDW       = rdw_i;
    ResultW   = resw_i;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] exp_byp;
  logic        live;

  initial begin
    rst = 1'b0; FlushE = 1'b0; InstrD = '0; PCD = '0; PCPlus4D = '0;
    RegWriteW = 1'b0; RDW = '0; ResultW = '0;

    //                rst flush instr         pc         wen rdw resw          ctl     rd1           rd2           imm           rs1 rs2 rd
    vecs.push_back(mk(0, 0, 32'h00028333, 32'h100, 0, 0, 32'h0,        C_NONE, 32'h0,        32'h0,        32'h0,        0,  0,  0));
    vecs.push_back(mk(0, 0, 32'h00028333, 32'h100, 0, 0, 32'h0,        C_NONE, 32'h0,        32'h0,        32'h0,        0,  0,  0));
    vecs.push_back(mk(1, 0, 32'h00028333, 32'h100, 0, 0, 32'h0,        C_ADD,  32'h0,        32'h0,        32'h0,        5,  0,  6));
    vecs.push_back(mk(1, 0, 32'h00000000, 32'h104, 1, 5, 32'hDEADBEEF, C_NONE, 32'h0,        32'h0,        32'h0,        0,  0,  0));
    vecs.push_back(mk(1, 0, 32'h00028333, 32'h108, 1, 0, 32'h00001234, C_ADD,  32'hDEADBEEF, 32'h0,        32'h0,        5,  0,  6));
    vecs.push_back(mk(1, 0, 32'h00028333, 32'h10C, 0, 0, 32'h0,        C_ADD,  32'hDEADBEEF, 32'h0,        32'h0,        5,  0,  6));
    vecs.push_back(mk(1, 0, 32'hFFC12083, 32'h110, 0, 0, 32'h0,        C_LW,   32'h0,        32'h0,        32'hFFFFFFFC, 2,  28, 1));
    vecs.push_back(mk(1, 0, 32'h00208463, 32'h114, 0, 0, 32'h0,        C_BEQ,  32'h0,        32'h0,        32'h00000008, 1,  2,  8));
    vecs.push_back(mk(1, 1, 32'h00208463, 32'h118, 0, 0, 32'h0,        C_NONE, 32'h0,        32'h0,        32'h0,        0,  0,  0));
    vecs.push_back(mk(1, 0, 32'h00208463, 32'h118, 0, 0, 32'h0,        C_BEQ,  32'h0,        32'h0,        32'h00000008, 1,  2,  8));
    vecs.push_back(mk(1, 0, 32'h406283B3, 32'h11C, 0, 0, 32'h0,        C_SUB,  32'hDEADBEEF, 32'h0,        32'h00000406, 5,  6,  7));
    vecs.push_back(mk(1, 0, 32'hFFF28413, 32'h120, 0, 0, 32'h0,        C_ADDI, 32'hDEADBEEF, 32'h0,        32'hFFFFFFFF, 5,  31, 8));
    vecs.push_back(mk(1, 0, 32'h0020A4B3, 32'h124, 0, 0, 32'h0,        C_SLT,  32'h0,        32'h0,        32'h00000002, 1,  2,  9));
    vecs.push_back(mk(1, 0, 32'h0020E4B3, 32'h128, 0, 0, 32'h0,        C_OR,   32'h0,        32'h0,        32'h00000002, 1,  2,  9));
    vecs.push_back(mk(1, 0, 32'h002094B3, 32'h12C, 0, 0, 32'h0,        C_ADD,  32'h0,        32'h0,        32'h00000002, 1,  2,  9));
    vecs.push_back(mk(1, 0, 32'h0F00F493, 32'h130, 0, 0, 32'h0,        C_ANDI, 32'h0,        32'h0,        32'h000000F0, 1,  16, 9));
    vecs.push_back(mk(1, 0, 32'hFE512C23, 32'h134, 0, 0, 32'h0,        C_SW,   32'h0,        32'hDEADBEEF, 32'hFFFFFFF8, 2,  5,  24));
    vecs.push_back(mk(1, 0, 32'h001000EF, 32'h138, 0, 0, 32'h0,        C_JAL,  32'h0,        32'h0,        32'h00000800, 0,  1,  1));
    vecs.push_back(mk(1, 0, 32'hFFDFF06F, 32'h13C, 0, 0, 32'h0,        C_JAL,  32'h0,        32'h0,        32'hFFFFFFFC, 31, 29, 0));
    vecs.push_back(mk(1, 0, 32'hFFF0007F, 32'h140, 0, 0, 32'h0,        C_NONE, 32'h0,        32'h0,        32'hFFFFFFFF, 0,  31, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].flush, vecs[i].instr, vecs[i].pc,
           vecs[i].wen, vecs[i].rdw, vecs[i].resw);
      live = vecs[i].rst && !vecs[i].flush;
      chk($sformatf("row%0d ctl", i),   {22'd0, act_ctl()},       {22'd0, vecs[i].ctl});
      chk($sformatf("row%0d rd1", i),   ex_if.RD1_E,              vecs[i].rd1);
      chk($sformatf("row%0d rd2", i),   ex_if.RD2_E,              vecs[i].rd2);
      chk($sformatf("row%0d imm", i),   ex_if.Imm_Ext_E,          vecs[i].imm);
      chk($sformatf("row%0d rs1", i),   {27'd0, ex_if.RS1_E},     {27'd0, vecs[i].rs1});
      chk($sformatf("row%0d rs2", i),   {27'd0, ex_if.RS2_E},     {27'd0, vecs[i].rs2});
      chk($sformatf("row%0d rd", i),    {27'd0, ex_if.RD_E},      {27'd0, vecs[i].rd});
      chk($sformatf("row%0d pc", i),    ex_if.PCE,                live ? vecs[i].pc : 32'h0);
      chk($sformatf("row%0d pc4", i),   ex_if.PCPlus4E,           live ? vecs[i].pc + 32'd4 : 32'h0);
    end

    // Same-cycle writeback to x7 while add x8,x7,x0 reads it.
`ifdef DECODE_WB_BYPASS_EN
    exp_byp = 32'hA5A5A5A5;
`else
    exp_byp = 32'h00000000;
`endif
    step(1, 0, 32'h00038433, 32'h200, 1, 7, 32'hA5A5A5A5);
    chk("bypass rd1", ex_if.RD1_E, exp_byp);
    chk("bypass rs1", {27'd0, ex_if.RS1_E}, 32'd7);
    step(1, 0, 32'h00038433, 32'h204, 0, 0, 32'h0);
    chk("post-write rd1", ex_if.RD1_E, 32'hA5A5A5A5);

    // Reset mid-operation together with a write to x10: reset wins, x5 clears.
    step(0, 0, 32'h00550033, 32'h208, 1, 10, 32'h00000055);
    chk("midrst ctl", {22'd0, act_ctl()}, {22'd0, C_NONE});
    chk("midrst pc", ex_if.PCE, 32'h0);
    chk("midrst rs2", {27'd0, ex_if.RS2_E}, 32'd0);
    step(1, 0, 32'h00550033, 32'h20C, 0, 0, 32'h0);
    chk("after rst x10", ex_if.RD1_E, 32'h0);
    chk("after rst x5", ex_if.RD2_E, 32'h0);
    chk("after rst ctl", {22'd0, act_ctl()}, {22'd0, C_ADD});
    chk("after rst rs2", {27'd0, ex_if.RS2_E}, 32'd5);

    // Flush still lets the writeback land in the register file.
    step(1, 1, 32'h00058033, 32'h210, 1, 11, 32'h11112222);
    chk("flushwr rd1", ex_if.RD1_E, 32'h0);
    chk("flushwr rs1", {27'd0, ex_if.RS1_E}, 32'd0);
    step(1, 0, 32'h00058033, 32'h214, 0, 0, 32'h0);
    chk("flushwr x11", ex_if.RD1_E, 32'h11112222);
    chk("flushwr pc", ex_if.PCE, 32'h214);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
